// File: rtl/jdv_life_controller.sv
// Game of Life controller: owns the cell map and cursor for the VGA generator, applies button
// edits, computes one cell per clock and commits on a frame boundary. Option macro: JDV_TORUS_EN.
module jdv_life_controller #(
  parameter int GRID_W  = 5,
  parameter int GRID_H  = 2,
  parameter int CELLS   = GRID_W * GRID_H,
  parameter int GEN_DIV = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_toggle,
  input  logic             btn_clear,
  input  logic             btn_step,
  input  logic             btn_run,
  input  logic             vga_vs,
  output logic [CELLS-1:0] vecteur_map,
  output logic [3:0]       largeur_grille,
  output logic [3:0]       hauteur_grille,
  output logic [3:0]       h_position_du_curseur,
  output logic [3:0]       v_position_du_curseur,
  output logic             running,
  output logic             busy,
  output logic [15:0]      gen_count
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPUTE = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;
  localparam logic [1:0] ST_COMMIT  = 2'd3;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [7:0]       idx_r;
  logic [3:0]       comp_x_r;
  logic [3:0]       comp_y_r;
  logic [CELLS-1:0] map_r;
  logic [CELLS-1:0] next_map_r;
  logic [3:0]       cur_x_r;
  logic [3:0]       cur_y_r;
  logic [3:0]       cur_x_nxt_s;
  logic [3:0]       cur_y_nxt_s;
  logic             running_r;
  logic             busy_r;
  logic [15:0]      gen_count_r;
  logic [15:0]      frame_cnt_r;
  logic             vs_d_r;

  logic             frame_tick_s;
  logic             is_idle_s;
  logic             edit_s;
  logic             gen_tick_s;
  logic             start_s;
  logic [7:0]       tog_idx_s;
  logic [CELLS-1:0] tog_mask_s;
  logic [CELLS-1:0] cell_mask_s;
  logic [3:0]       nbr_s;
  logic             alive_s;
  logic             next_bit_s;

  // Live neighbours of (x,y); each of the 8 offsets contributes at most once.
  function automatic logic [3:0] nbr_count(input logic [CELLS-1:0] map,
                                           input logic [3:0] x,
                                           input logic [3:0] y);
    logic [3:0]       n;
    logic [CELLS-1:0] sh;
    logic             vld;
    int               nx;
    int               ny;
    int               bi;
    n = 4'd0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        nx = int'(x) + dx;
        ny = int'(y) + dy;
`ifdef JDV_TORUS_EN
        if (nx < 0) nx = nx + GRID_W;
        else if (nx >= GRID_W) nx = nx - GRID_W;
        else nx = nx;
        if (ny < 0) ny = ny + GRID_H;
        else if (ny >= GRID_H) ny = ny - GRID_H;
        else ny = ny;
        vld = 1'b1;
`else
        vld = (nx >= 0) && (nx < GRID_W) && (ny >= 0) && (ny < GRID_H);
`endif
        if (vld) bi = nx + ny * GRID_W;
        else bi = 0;
        sh = map >> bi;
        if (vld && !((dx == 0) && (dy == 0))) n = n + {3'b000, sh[0]};
        else n = n;
      end
    end
    return n;
  endfunction

  assign frame_tick_s = vs_d_r & ~vga_vs;
  assign is_idle_s    = (state_r == ST_IDLE);
  assign edit_s       = is_idle_s & (btn_clear | btn_toggle);
  assign gen_tick_s   = running_r & frame_tick_s & (frame_cnt_r == 16'(GEN_DIV - 1));
  assign start_s      = is_idle_s & ~edit_s & ((btn_step & ~running_r) | gen_tick_s);
  assign tog_idx_s    = 8'(int'(cur_x_r) + int'(cur_y_r) * GRID_W);
  assign tog_mask_s   = CELLS'(1'b1) << tog_idx_s;
  assign cell_mask_s  = CELLS'(1'b1) << idx_r;
  assign nbr_s        = nbr_count(map_r, comp_x_r, comp_y_r);
  assign alive_s      = |(map_r & cell_mask_s);
  assign next_bit_s   = (nbr_s == 4'd3) | (alive_s & (nbr_s == 4'd2));

  // Clamped cursor moves; opposing presses cancel.
  always_comb begin
    cur_x_nxt_s = cur_x_r;
    cur_y_nxt_s = cur_y_r;
    if (btn_left && !btn_right && (cur_x_r != 4'd0)) cur_x_nxt_s = cur_x_r - 4'd1;
    else if (btn_right && !btn_left && (cur_x_r != 4'(GRID_W - 1))) cur_x_nxt_s = cur_x_r + 4'd1;
    else cur_x_nxt_s = cur_x_r;
    if (btn_up && !btn_down && (cur_y_r != 4'd0)) cur_y_nxt_s = cur_y_r - 4'd1;
    else if (btn_down && !btn_up && (cur_y_r != 4'(GRID_H - 1))) cur_y_nxt_s = cur_y_r + 4'd1;
    else cur_y_nxt_s = cur_y_r;
  end

  // Generation FSM next state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_nxt_s = ST_COMPUTE;
        else state_nxt_s = ST_IDLE;
      end
      ST_COMPUTE: begin
        if (idx_r == 8'(CELLS - 1)) state_nxt_s = ST_PENDING;
        else state_nxt_s = ST_COMPUTE;
      end
      ST_PENDING: begin
        if (frame_tick_s) state_nxt_s = ST_COMMIT;
        else state_nxt_s = ST_PENDING;
      end
      ST_COMMIT: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state, compute walker and the shadow map being built.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      idx_r      <= 8'd0;
      comp_x_r   <= 4'd0;
      comp_y_r   <= 4'd0;
      next_map_r <= '0;
      busy_r     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_COMPUTE) | (state_nxt_s == ST_PENDING);
      if (start_s) begin
        idx_r    <= 8'd0;
        comp_x_r <= 4'd0;
        comp_y_r <= 4'd0;
      end else if (state_r == ST_COMPUTE) begin
        next_map_r <= next_bit_s ? (next_map_r | cell_mask_s) : (next_map_r & ~cell_mask_s);
        idx_r      <= idx_r + 8'd1;
        if (comp_x_r == 4'(GRID_W - 1)) begin
          comp_x_r <= 4'd0;
          comp_y_r <= comp_y_r + 4'd1;
        end else begin
          comp_x_r <= comp_x_r + 4'd1;
        end
      end
    end
  end

  // Displayed map: user edits in IDLE, whole-map commit in COMMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      map_r       <= '0;
      gen_count_r <= 16'd0;
    end else if (state_r == ST_COMMIT) begin
      map_r       <= next_map_r;
      gen_count_r <= gen_count_r + 16'd1;
    end else if (edit_s) begin
      if (btn_clear) map_r <= '0;
      else map_r <= map_r ^ tog_mask_s;
    end
  end

  // Cursor, run mode, frame divider and vsync edge detector.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_x_r     <= 4'd0;
      cur_y_r     <= 4'd0;
      running_r   <= 1'b0;
      frame_cnt_r <= 16'd0;
      vs_d_r      <= 1'b1;
    end else begin
      cur_x_r <= cur_x_nxt_s;
      cur_y_r <= cur_y_nxt_s;
      vs_d_r  <= vga_vs;
      if (btn_run) running_r <= ~running_r;
      if (!running_r) frame_cnt_r <= 16'd0;
      else if (frame_tick_s) begin
        if (frame_cnt_r == 16'(GEN_DIV - 1)) frame_cnt_r <= 16'd0;
        else frame_cnt_r <= frame_cnt_r + 16'd1;
      end
    end
  end

  assign vecteur_map           = map_r;
  assign largeur_grille        = 4'(GRID_W);
  assign hauteur_grille        = 4'(GRID_H);
  assign h_position_du_curseur = cur_x_r;
  assign v_position_du_curseur = cur_y_r;
  assign running               = running_r;
  assign busy                  = busy_r;
  assign gen_count             = gen_count_r;

endmodule

// File: tb/tb_jdv_life_controller.sv
// Scoreboard bench for jdv_life_controller on a 5x2 grid with GEN_DIV=2; snapshot and commit
// expectations are queued by the stimulus and checked by an independent monitor.
module tb_jdv_life_controller;
  localparam int GW = 5;
  localparam int GH = 2;
  localparam int NC = GW * GH;
  localparam int GD = 2;

  localparam int F_MAP = 0, F_CX = 1, F_CY = 2, F_RUN = 3, F_BUSY = 4, F_GEN = 5, F_W = 6, F_H = 7;
  localparam int B_L = 1, B_R = 2, B_U = 4, B_D = 8, B_T = 16, B_C = 32, B_S = 64, B_RUN = 128;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic btn_toggle = 1'b0, btn_clear = 1'b0, btn_step = 1'b0, btn_run = 1'b0;
  logic vga_vs = 1'b1;
  logic [NC-1:0] vecteur_map;
  logic [3:0] largeur_grille, hauteur_grille, h_position_du_curseur, v_position_du_curseur;
  logic running, busy;
  logic [15:0] gen_count;

  jdv_life_controller #(.GRID_W(GW), .GRID_H(GH), .CELLS(NC), .GEN_DIV(GD)) dut (
    .clk(clk), .reset(reset),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
    .btn_toggle(btn_toggle), .btn_clear(btn_clear), .btn_step(btn_step), .btn_run(btn_run),
    .vga_vs(vga_vs), .vecteur_map(vecteur_map),
    .largeur_grille(largeur_grille), .hauteur_grille(hauteur_grille),
    .h_position_du_curseur(h_position_du_curseur), .v_position_du_curseur(v_position_du_curseur),
    .running(running), .busy(busy), .gen_count(gen_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int q_fld[$];
  logic [31:0] q_val[$];
  string q_name[$];
  logic [NC-1:0] c_map[$];
  logic [15:0] c_gen[$];
  logic mon_en = 1'b0;
  logic [15:0] last_gen = 16'd0;
  logic [15:0] exp_gen = 16'd0;

  function automatic logic [31:0] observe(input int f);
    case (f)
      F_MAP:   return 32'(vecteur_map);
      F_CX:    return 32'(h_position_du_curseur);
      F_CY:    return 32'(v_position_du_curseur);
      F_RUN:   return 32'(running);
      F_BUSY:  return 32'(busy);
      F_GEN:   return 32'(gen_count);
      F_W:     return 32'(largeur_grille);
      F_H:     return 32'(hauteur_grille);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: drains snapshot expectations each negedge and checks every commit as it appears.
  initial begin
    int f;
    logic [31:0] v, act;
    logic [NC-1:0] em;
    logic [15:0] eg;
    string nm;
    forever begin
      @(negedge clk);
      while (q_fld.size() > 0) begin
        f = q_fld.pop_front();
        v = q_val.pop_front();
        nm = q_name.pop_front();
        act = observe(f);
        n_vec++;
        if (act !== v) begin
          n_err++;
          $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, v);
        end
      end
      if (mon_en && (gen_count !== last_gen)) begin
        if (c_map.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_commit: gen_count 0x%0h, expected it to stay 0x%0h", gen_count, last_gen);
        end else begin
          em = c_map.pop_front();
          eg = c_gen.pop_front();
          n_vec++;
          if (vecteur_map !== em) begin
            n_err++;
            $display("FAIL commit_map: got 0x%0h, expected 0x%0h", vecteur_map, em);
          end
          n_vec++;
          if (gen_count !== eg) begin
            n_err++;
            $display("FAIL commit_gen: got 0x%0h, expected 0x%0h", gen_count, eg);
          end
        end
        last_gen = gen_count;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btns(input int b);
    btn_left   = b[0];
    btn_right  = b[1];
    btn_up     = b[2];
    btn_down   = b[3];
    btn_toggle = b[4];
    btn_clear  = b[5];
    btn_step   = b[6];
    btn_run    = b[7];
  endtask

  task automatic pulse(input int b);
    set_btns(b);
    tick();
    set_btns(0);
  endtask

  task automatic pulse_n(input int b, input int n);
    for (int i = 0; i < n; i++) pulse(b);
  endtask

  task automatic expect_now(input int f, input logic [31:0] v, input string nm);
    q_fld.push_back(f);
    q_val.push_back(v);
    q_name.push_back(nm);
  endtask

  task automatic expect_commit(input logic [NC-1:0] m);
    exp_gen = exp_gen + 16'd1;
    c_map.push_back(m);
    c_gen.push_back(exp_gen);
  endtask

  // One vsync pulse; a commit from PENDING is visible on return.
  task automatic frame();
    vga_vs = 1'b0;
    tick();
    vga_vs = 1'b1;
    tick();
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    last_gen = 16'd0;
    mon_en = 1'b1;
    expect_now(F_MAP, 32'h0, "reset_map");
    expect_now(F_CX, 32'd0, "reset_cx");
    expect_now(F_CY, 32'd0, "reset_cy");
    expect_now(F_RUN, 32'd0, "reset_running");
    expect_now(F_BUSY, 32'd0, "reset_busy");
    expect_now(F_GEN, 32'd0, "reset_gen");
    expect_now(F_W, 32'd5, "grid_w");
    expect_now(F_H, 32'd2, "grid_h");
    tick();

    // Cursor clamp and opposing presses.
    pulse_n(B_L, 3);        expect_now(F_CX, 32'd0, "clamp_left");
    pulse_n(B_U, 2);        expect_now(F_CY, 32'd0, "clamp_up");
    pulse_n(B_R, 7);        expect_now(F_CX, 32'd4, "clamp_right");
    pulse_n(B_D, 3);        expect_now(F_CY, 32'd1, "clamp_down");
    pulse(B_L | B_R);       expect_now(F_CX, 32'd4, "left_right_cancel");
    pulse(B_U | B_D);       expect_now(F_CY, 32'd1, "up_down_cancel");
    pulse_n(B_L, 2);        expect_now(F_CX, 32'd2, "cursor_x2");

    pulse(B_T);             expect_now(F_MAP, 32'h080, "toggle_2_1");
    pulse(B_T | B_C);       expect_now(F_MAP, 32'h000, "clear_wins");

    // Block still life at the bottom edge.
    pulse(B_L); pulse(B_T); pulse(B_U); pulse(B_T);
    pulse(B_R); pulse(B_T); pulse(B_D); pulse(B_T);
    expect_now(F_MAP, 32'h0C6, "block_map");
    expect_commit(10'h0C6);
    pulse(B_S);             expect_now(F_BUSY, 32'd1, "busy_after_step");
    repeat (9) tick();
    vga_vs = 1'b0;          expect_now(F_BUSY, 32'd1, "busy_last_compute");
    tick();
    vga_vs = 1'b1;
    tick();
    expect_now(F_GEN, 32'd0, "tick_in_compute_ignored");
    expect_now(F_BUSY, 32'd1, "busy_pending");
    frame();
    expect_now(F_BUSY, 32'd0, "idle_after_commit");
    tick();

    // Isolated cell dies; edit while busy is ignored.
    pulse(B_C);             expect_now(F_MAP, 32'h000, "clear");
    pulse_n(B_L, 2); pulse(B_U);
    pulse(B_T);             expect_now(F_MAP, 32'h001, "single_cell");
    expect_commit(10'h000);
    pulse(B_S);
    pulse(B_T);             expect_now(F_MAP, 32'h001, "toggle_while_busy");
    repeat (12) tick();
    frame();
    tick();

    // Row of three on row 0 becomes a vertical pair.
    pulse(B_R); pulse(B_T); pulse(B_R); pulse(B_T); pulse(B_R); pulse(B_T);
    expect_now(F_MAP, 32'h00E, "row_map");
    expect_commit(10'h084);
    pulse(B_S);
    repeat (12) tick();
    frame();
    tick();

    // Run mode: a generation every GEN_DIV frames, then stop.
    pulse(B_C);
    pulse(B_L); pulse(B_T); pulse(B_L); pulse(B_T);
    pulse(B_D); pulse(B_T); pulse(B_R); pulse(B_T);
    expect_now(F_MAP, 32'h0C6, "run_block_map");
    pulse(B_RUN);           expect_now(F_RUN, 32'd1, "running_on");
    expect_commit(10'h0C6);
    expect_commit(10'h0C6);
    for (int k = 0; k < 5; k++) begin
      repeat (20) tick();
      frame();
    end
    expect_now(F_GEN, 32'd5, "run_gen_count");
    pulse(B_RUN);           expect_now(F_RUN, 32'd0, "running_off");
    for (int k = 0; k < 4; k++) begin
      repeat (20) tick();
      frame();
    end
    expect_now(F_GEN, 32'd5, "stopped_gen_count");
    expect_now(F_BUSY, 32'd0, "stopped_busy");
    repeat (3) tick();

    while (c_map.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL missing_commit: gen_count 0x%0h, expected commit 0x%0h", gen_count, c_gen.pop_front());
      void'(c_map.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
